// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Command sequencer driving the 16-bit accumulator ALU pin
//               protocol (load, execute, read, capture) with valid/ready
//               command and result ports. Optional macro ALU_SEQ_PERF_EN
//               adds a saturating completed-result counter (perf_count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int               OPW    = 5,
  parameter int               DW     = 16,
  parameter logic [OPW-1:0]   NOP_OP = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_load,
  input  logic [OPW-1:0]  cmd_op,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic            res_flag,
  output logic            busy,
  output logic [OPW-1:0]  alu_opcode,
  output logic [DW-1:0]   alu_operand,
  output logic            alu_write,
  output logic            alu_read,
  input  logic [DW-1:0]   alu_accout,
  input  logic            alu_flag
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]     perf_count
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_CAPT = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]     r_state;
  logic [OPW-1:0] r_op;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic           r_load;
  logic           r_res_valid;
  logic [DW-1:0]  r_res_data;
  logic           r_res_flag;
  logic           w_accept;

  // cmd_ready is gated by rst_n so it reads 0 throughout reset assertion.
  assign cmd_ready = rst_n && (r_state == S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign busy      = (r_state != S_IDLE);
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_flag  = r_res_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= NOP_OP;
      r_a         <= '0;
      r_b         <= '0;
      r_load      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_flag  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd_op;
            r_a     <= cmd_a;
            r_b     <= cmd_b;
            r_load  <= cmd_load;
            r_state <= cmd_load ? S_LOAD : S_EXEC;
          end
        end
        S_LOAD: r_state <= S_EXEC;
        S_EXEC: r_state <= S_READ;
        S_READ: r_state <= S_CAPT;
        S_CAPT: begin
          r_res_data  <= alu_accout;
          r_res_flag  <= alu_flag;
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ALU pins decode purely from registered state and the latched command.
  always_comb begin
    alu_opcode  = NOP_OP;
    alu_operand = '0;
    alu_write   = 1'b0;
    alu_read    = 1'b0;
    case (r_state)
      S_LOAD: begin
        alu_operand = r_a;
        alu_write   = r_load;
      end
      S_EXEC: begin
        alu_opcode  = r_op;
        alu_operand = r_b;
      end
      S_READ: alu_read = 1'b1;
      default: ;
    endcase
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] r_perf_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_count <= 16'h0000;
    end else if (r_res_valid && res_ready && (r_perf_count != 16'hFFFF)) begin
      r_perf_count <= r_perf_count + 16'h0001;
    end
  end

  assign perf_count = r_perf_count;
`endif

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command sequencer for the 16-bit accumulator ALU (opcode/operand/write/read pins, accout/flag results). It accepts one command per valid/ready handshake and drives the ALU pin protocol: optional accumulator load, operation cycle, then read strobe. It captures accout/flag and returns them through a valid/ready result port with backpressure. It sits between the control unit and the ALU and owns all ALU pins.

Parameters:
OPW, 5, ALU opcode width
DW, 16, ALU data width
NOP_OP, 5'h00, opcode driven during load, read and idle cycles

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_load  in  1  load accumulator with cmd_a before the operation
cmd_op  in  OPW  ALU opcode to execute
cmd_a  in  DW  accumulator load value (used only if cmd_load=1)
cmd_b  in  DW  operand for the operation cycle
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  DW  captured accout
res_flag  out  1  captured flag
busy  out  1  state != IDLE
alu_opcode  out  OPW  to ALU opcode
alu_operand  out  DW  to ALU operand
alu_write  out  1  to ALU write (accumulator load)
alu_read  out  1  to ALU read strobe
alu_accout  in  DW  from ALU accout
alu_flag  in  1  from ALU flag

Behaviour:
- States: IDLE, LOAD, EXEC, READ, CAPT, RESP. State, latched command (op, a, b, load) and result are registers.
- alu_* outputs decode only from the state and latched-command registers. No combinational path exists from cmd_* to alu_*.
- alu_write and alu_read are never high in the same cycle.
- IDLE: cmd_ready=1, alu_opcode=NOP_OP, alu_operand=0, alu_write=0, alu_read=0.
  - On cmd_valid & cmd_ready: latch op, a, b, load. Go to LOAD if load=1, else EXEC.
- LOAD (1 cycle): alu_opcode=NOP_OP, alu_operand=a, alu_write=1 -> EXEC.
- EXEC (1 cycle): alu_opcode=op, alu_operand=b, write=0, read=0 -> READ. op=NOP_OP is legal and is issued as-is.
- READ (1 cycle): alu_opcode=NOP_OP, alu_operand=0, alu_read=1 -> CAPT.
- CAPT (1 cycle): ALU pins idle. At the closing edge: res_data<=alu_accout, res_flag<=alu_flag, res_valid<=1 -> RESP.
- RESP: res_valid=1; res_data and res_flag held stable. On res_ready=1, at the edge: res_valid<=0 -> IDLE.
  - res_ready may be high on the first RESP cycle.
  - cmd_ready=0 in every state except IDLE, so there is no back-to-back acceptance. Peak throughput is one command per 6 cycles (load) or 5 cycles (no load).
- Latency, counting from the accept edge as 0: res_valid first high in cycle 5 with load, cycle 4 without.
- res_data/res_flag are updated only in CAPT. They keep their last value after the handshake.
- Reset (rst_n=0 at a rising edge), in any state including mid-LOAD/EXEC/READ:
  - state=IDLE; res_valid, res_data, res_flag and all alu_* = 0 (alu_opcode=NOP_OP); busy=0.
  - cmd_ready=0 while rst_n is low, 1 from the first cycle after release.
  - The in-flight command is dropped with no result.
  - The ALU accumulator is not cleared by the sequencer.
- The sequencer holds the ALU pins idle in every state except LOAD/EXEC/READ.

Optional Feature:
ALU_SEQ_PERF_EN
- Defined: extra output port perf_count (out, 16). It counts completed result handshakes (res_valid & res_ready), saturates at 16'hFFFF, and is cleared by reset.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n low 2 cycles -> all outputs 0, alu_opcode=5'h00, cmd_ready=0. First cycle after release -> cmd_ready=1, busy=0.
- Load+op: cmd_load=1, a=16'hFFFE, op=5'h02, b=16'h0005, res_ready=1; ALU stub returns accout=16'h0003, flag=1. Expected pins and result:
  - cycle 1: alu_write=1, alu_operand=FFFE.
  - cycle 2: alu_opcode=02, alu_operand=0005.
  - cycle 3: alu_read=1.
  - cycle 5: res_valid=1, res_data=0003, res_flag=1.
  - cycle 6: IDLE.
- No load: cmd_load=0, op=5'h0E, b=16'h0000 -> no alu_write pulse; EXEC in cycle 1, alu_read in cycle 2, res_valid in cycle 4.
- Backpressure: res_ready=0 for 10 cycles while cmd_valid=1 with new data -> res_valid, res_data, res_flag stable; cmd_ready=0; no ALU activity. Raise res_ready -> IDLE next cycle, then the pending command is accepted.
- Reset mid-EXEC: assert rst_n=0 in the EXEC cycle -> next cycle all alu_*=0, busy=0; no res_valid ever appears for that command.
- With ALU_SEQ_PERF_EN: 3 completed commands -> perf_count=3. Force the counter to 16'hFFFF, complete 1 more -> perf_count stays 16'hFFFF.
